// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU definitions for the responder RTL, driver, monitor and
// scoreboard.
//   ALU_DATA_W : default operand/result width
//   alu_op_e   : 4-bit opcode encoding, OP_ADD (0x0) .. OP_CLR (0xF)
package alu_pkg;
    localparam int ALU_DATA_W = 8;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBB = 4'h3,
        OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7,
        OP_SHL = 4'h8, OP_SHR = 4'h9, OP_ROL = 4'hA, OP_ROR = 4'hB,
        OP_INC = 4'hC, OP_DEC = 4'hD, OP_ACC = 4'hE, OP_CLR = 4'hF
    } alu_op_e;
endpackage

// File: rtl/alu_exec.sv
// alu_exec: purely combinational ALU datapath used in stage 2.
//   a, b    : operands
//   op      : opcode
//   cf, acc : current carry flag / accumulator state
//   y, co   : result and carry/borrow/shifted-out bit
//   acc_nxt : accumulator value after this op
//   cf_nxt  : carry flag value after this op
module alu_exec
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    input  logic              cf,
    input  logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] y,
    output logic              co,
    output logic [DATA_W-1:0] acc_nxt,
    output logic              cf_nxt
);
    // One bit wider than the data: the top bit is the carry for additions,
    // the borrow for subtractions (wraps negative) and the shifted-out bit
    // for shifts/rotates.
    logic [DATA_W:0] r;
    logic [DATA_W:0] a_x, b_x, cf_x;

    assign a_x  = {1'b0, a};
    assign b_x  = {1'b0, b};
    assign cf_x = {{DATA_W{1'b0}}, cf};

    always_comb begin
        r       = '0;
        acc_nxt = acc;
        case (op)
            OP_ADD: r = a_x + b_x;
            OP_ADC: r = a_x + b_x + cf_x;
            OP_SUB: r = a_x - b_x;
            OP_SBB: r = a_x - b_x - cf_x;
            OP_AND: r = {1'b0, a & b};
            OP_OR:  r = {1'b0, a | b};
            OP_XOR: r = {1'b0, a ^ b};
            OP_NOT: r = {1'b0, ~a};
            OP_SHL: r = {a, 1'b0};
            OP_SHR: r = {a[0], 1'b0, a[DATA_W-1:1]};
            OP_ROL: r = {a, a[DATA_W-1]};
            OP_ROR: r = {a[0], a[0], a[DATA_W-1:1]};
            OP_INC: r = a_x + (DATA_W+1)'(1);
            OP_DEC: r = a_x - (DATA_W+1)'(1);
            OP_ACC: begin
                r       = {1'b0, acc} + a_x;
                acc_nxt = r[DATA_W-1:0];
            end
            OP_CLR: begin
                r       = '0;
                acc_nxt = '0;
            end
        endcase
    end

    assign y      = r[DATA_W-1:0];
    assign co     = r[DATA_W];
    assign cf_nxt = r[DATA_W];
endmodule

// File: rtl/alu_pipe_responder.sv
// alu_pipe_responder: two-stage registered ALU (responder side of the ALU
// interface) with valid qualifier, carry flag and accumulator state.
//   clk, reset            : rising-edge clock, async active-high reset
//   alu_a_in, alu_b_in    : operands
//   alu_opcode_in         : operation select (alu_op_e encoding)
//   alu_in_valid          : operands/opcode valid this cycle
//   alu_y_out, alu_co_out : registered result and carry/borrow bit
//   alu_out_valid         : one-cycle pulse per accepted op, two edges later
module alu_pipe_responder
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_a_in,
    input  logic [DATA_W-1:0] alu_b_in,
    input  logic [3:0]        alu_opcode_in,
    input  logic              alu_in_valid,
    output logic [DATA_W-1:0] alu_y_out,
    output logic              alu_co_out,
    output logic              alu_out_valid
);
    // vld_pipe[1]: stage-1 register holds a valid op; vld_pipe[2]: output valid
    logic [2:1]        vld_pipe;
    logic [DATA_W-1:0] s1_a, s1_b;
    alu_op_e           s1_op;
    logic              cf;
    logic [DATA_W-1:0] acc;

    logic [DATA_W-1:0] ex_y, ex_acc_nxt;
    logic              ex_co, ex_cf_nxt;

    alu_exec #(.DATA_W(DATA_W)) u_exec (
        .a       (s1_a),
        .b       (s1_b),
        .op      (s1_op),
        .cf      (cf),
        .acc     (acc),
        .y       (ex_y),
        .co      (ex_co),
        .acc_nxt (ex_acc_nxt),
        .cf_nxt  (ex_cf_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe   <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_op      <= OP_ADD;
            cf         <= 1'b0;
            acc        <= '0;
            alu_y_out  <= '0;
            alu_co_out <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[1], alu_in_valid};
            s1_a     <= alu_a_in;
            s1_b     <= alu_b_in;
            s1_op    <= alu_op_e'(alu_opcode_in);
            // cf/acc update on the same edge as the outputs, so the op now
            // entering stage 2 already sees the state left by its predecessor.
            if (vld_pipe[1]) begin
                alu_y_out  <= ex_y;
                alu_co_out <= ex_co;
                cf         <= ex_cf_nxt;
                acc        <= ex_acc_nxt;
            end
        end
    end

    assign alu_out_valid = vld_pipe[2];
endmodule
